audio_i2s_dac_tx: RTL and testbench
===================================

AUDIO_I2S_DAC_TX -- requirements
Module: audio_i2s_dac_tx

Parameters
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, meaning bits per channel sample.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning stereo words buffered (power of two, >=2).

Interface
REQ-003 The block SHALL have port clk, input, 1, the single system clock; it is >= 8x BCLK frequency.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port enable, input, 1; high runs the serializer, low forces IDLE with the FIFO retained.
REQ-006 The block SHALL have port sample_data, input, 2*DATA_WIDTH, carrying {left, right}.
REQ-007 The block SHALL have port sample_valid, input, 1, the producer strobe.
REQ-008 The block SHALL have port sample_ready, output, 1, high when the FIFO is not full.
REQ-009 The block SHALL have port BCLK, input, 1, the codec bit clock (codec is master); it is asynchronous to clk.
REQ-010 The block SHALL have port DACLRC, input, 1, the codec frame clock (low = left, high = right); it is asynchronous to clk.
REQ-011 The block SHALL have port DACDAT, output, 1, serial data to the codec.
REQ-012 The block SHALL have port underflow, output, 1, a sticky flag.
REQ-013 The block SHALL have port underflow_clr, input, 1, which clears underflow.
REQ-014 The block SHALL have port fifo_level, output, clog2(FIFO_DEPTH)+1, the current FIFO occupancy.

Function
REQ-015 BCLK and DACLRC SHALL each pass through a 2-flop synchronizer plus 1 history flop; edge pulses are single clk cycles, 3 clk after the pin edge.
REQ-016 A push SHALL occur when sample_valid && sample_ready; valid while full SHALL be ignored, with no overwrite.
REQ-017 A simultaneous push and pop SHALL both take effect, leaving fifo_level unchanged; a push into an empty FIFO is poppable the next cycle.
REQ-018 On a DACLRC falling edge (left frame start) with enable high, the block SHALL pop one word into holding registers; if the FIFO is empty it SHALL load zeros and set underflow.
REQ-019 The DACLRC rising edge SHALL NOT pop; it SHALL use the right half captured at the preceding left-frame pop.
REQ-020 FSM states SHALL be IDLE, WAIT_MSB, SHIFT and PAD.
REQ-021 IDLE -> WAIT_MSB SHALL occur on a DACLRC falling edge with enable high; a rising edge is ignored in IDLE, so output always starts on a left channel.
REQ-022 WAIT_MSB SHALL load the channel word into the shift register; on the next BCLK falling edge DACDAT SHALL take the MSB (I2S one-bit delay) -> SHIFT.
REQ-023 SHIFT SHALL, on each BCLK falling edge, shift out the next bit MSB-first via a bit counter; after DATA_WIDTH bits have been driven -> PAD.
REQ-024 PAD SHALL drive DACDAT=0 on BCLK falling edges until the next DACLRC edge.
REQ-025 Any DACLRC edge in SHIFT or PAD SHALL -> WAIT_MSB with the other channel's word, truncating an unfinished word.
REQ-026 DACDAT SHALL change only in the clk cycle following a synchronized BCLK falling edge; it SHALL NOT change on rising edges.
REQ-027 enable low in any state SHALL -> IDLE next cycle with DACDAT=0, no pop, FIFO contents and underflow unchanged.
REQ-028 underflow_clr SHALL clear the flag; if clear and set coincide, set SHALL win.

Reset
REQ-029 On reset assertion the block SHALL asynchronously set FSM=IDLE, DACDAT=0, FIFO pointers=0, fifo_level=0, sample_ready=1, underflow=0, shift register and bit counter=0, and synchronizer flops=0.
REQ-030 After deassertion the block SHALL not emit data until the first synchronized DACLRC falling edge, even if reset released mid-frame.

Verification
REQ-031 The bench SHALL cover: push 0xA5F0_0F5A, run BCLK=3.072 MHz and DACLRC=48 kHz -> left bits 1010010111110000 then right 0000111101011010, MSB one BCLK after each DACLRC edge, PAD zeros after.
REQ-032 The bench SHALL cover: push 5 words with no DACLRC activity -> sample_ready=0 after word 4, fifo_level=4, 5th not stored; after one left-frame pop, level=3 and ready=1.
REQ-033 The bench SHALL cover: empty FIFO at a DACLRC falling edge -> DACDAT all 0 for the frame, underflow=1; pulse underflow_clr -> 0; clr coincident with a new underflow -> remains 1.
REQ-034 The bench SHALL cover: push and pop in the same clk with level=2 -> level stays 2, popped word is the oldest.
REQ-035 The bench SHALL cover: assert reset mid-SHIFT -> DACDAT=0 immediately, fifo_level=0; release reset while DACLRC high -> DACDAT stays 0 until the next DACLRC falling edge, then the left word streams.
REQ-036 The bench SHALL cover: deassert enable mid-word -> DACDAT=0 within 1 clk, level unchanged; reassert -> output resumes at the next left frame.

Source files
------------

// File: rtl/audio_i2s_dac_tx.sv
// I2S transmitter for a codec acting as bus master: a small stereo FIFO feeds a serializer
// that follows the codec's BCLK/DACLRC, sampled by the fast system clock.
module audio_i2s_dac_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [2*DATA_WIDTH-1:0]       sample_data,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    input  logic                          BCLK,
    input  logic                          DACLRC,
    output logic                          DACDAT,
    output logic                          underflow,
    input  logic                          underflow_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MSB = 2'd1,
        SHIFT    = 2'd2,
        PAD      = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              bclk_sync_q;
    logic [2:0]              lrc_sync_q;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0]   right_q, right_d;
    logic [CNT_W-1:0]        bitcnt_q, bitcnt_d;
    logic                    dacdat_q, dacdat_d;
    logic                    underflow_q, underflow_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]        level_q, level_d;
    logic                    ready_q, ready_d;
    logic [2*DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];

    logic                    bclk_fall;
    logic                    lrc_fall;
    logic                    lrc_rise;
    logic                    push;
    logic                    pop;
    logic                    fifo_empty;
    logic [2*DATA_WIDTH-1:0] head;

    // Edge pulses compare the second synchronizer stage against the history stage.
    always_comb begin
        bclk_fall  = bclk_sync_q[2] & ~bclk_sync_q[1];
        lrc_fall   = lrc_sync_q[2] & ~lrc_sync_q[1];
        lrc_rise   = ~lrc_sync_q[2] & lrc_sync_q[1];
        fifo_empty = (level_q == LVL_W'(0));
        head       = fifo_mem_q[rd_ptr_q];
        push       = sample_valid & ready_q;
        pop        = enable & lrc_fall & ~fifo_empty;
    end

    // FIFO bookkeeping: pointers, occupancy and the not-full indication.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        ready_d = (level_d != LVL_W'(FIFO_DEPTH));
    end

    // Serializer next state; a frame edge always wins over a coincident bit-clock edge.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        right_d     = right_q;
        bitcnt_d    = bitcnt_q;
        dacdat_d    = dacdat_q;
        underflow_d = underflow_q;
        if (!enable) begin
            state_d  = IDLE;
            shreg_d  = '0;
            bitcnt_d = '0;
            dacdat_d = 1'b0;
        end else if (lrc_fall) begin
            state_d  = WAIT_MSB;
            bitcnt_d = '0;
            dacdat_d = bclk_fall ? 1'b0 : dacdat_q;
            if (fifo_empty) begin
                shreg_d = '0;
                right_d = '0;
            end else begin
                shreg_d = head[2*DATA_WIDTH-1:DATA_WIDTH];
                right_d = head[DATA_WIDTH-1:0];
            end
        end else if (lrc_rise && (state_q != IDLE)) begin
            state_d  = WAIT_MSB;
            shreg_d  = right_q;
            bitcnt_d = '0;
            dacdat_d = bclk_fall ? 1'b0 : dacdat_q;
        end else if (bclk_fall) begin
            case (state_q)
                IDLE: begin
                    dacdat_d = 1'b0;
                end
                WAIT_MSB: begin
                    dacdat_d = shreg_q[DATA_WIDTH-1];
                    shreg_d  = {shreg_q[DATA_WIDTH-2:0], 1'b0};
                    bitcnt_d = CNT_W'(1);
                    state_d  = SHIFT;
                end
                SHIFT: begin
                    dacdat_d = shreg_q[DATA_WIDTH-1];
                    shreg_d  = {shreg_q[DATA_WIDTH-2:0], 1'b0};
                    bitcnt_d = bitcnt_q + CNT_W'(1);
                    if (bitcnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                        state_d = PAD;
                    end else begin
                        state_d = SHIFT;
                    end
                end
                PAD: begin
                    dacdat_d = 1'b0;
                end
                default: begin
                    state_d  = IDLE;
                    dacdat_d = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        // A new underflow takes precedence over a simultaneous clear.
        if (enable && lrc_fall && fifo_empty) begin
            underflow_d = 1'b1;
        end else if (underflow_clr) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // All control state, synchronizers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bclk_sync_q <= 3'b000;
            lrc_sync_q  <= 3'b000;
            shreg_q     <= '0;
            right_q     <= '0;
            bitcnt_q    <= '0;
            dacdat_q    <= 1'b0;
            underflow_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            bclk_sync_q <= {bclk_sync_q[1:0], BCLK};
            lrc_sync_q  <= {lrc_sync_q[1:0], DACLRC};
            shreg_q     <= shreg_d;
            right_q     <= right_d;
            bitcnt_q    <= bitcnt_d;
            dacdat_q    <= dacdat_d;
            underflow_q <= underflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ready_q     <= ready_d;
        end
    end

    // Sample storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= sample_data;
        end
    end

    assign sample_ready = ready_q;
    assign DACDAT       = dacdat_q;
    assign underflow    = underflow_q;
    assign fifo_level   = level_q;

endmodule

// File: tb/tb_audio_i2s_dac_tx.sv
// Directed bench for audio_i2s_dac_tx: a behavioural codec drives BCLK/DACLRC and
// captures DACDAT on BCLK rising edges, one 32-bit slot per channel.
`timescale 1ns/1ps
module tb_audio_i2s_dac_tx;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [31:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic        BCLK;
    logic        DACLRC;
    logic        DACDAT;
    logic        underflow;
    logic        underflow_clr;
    logic [2:0]  fifo_level;

    int          chk_cnt;
    int          pass_cnt;
    logic [31:0] pp_word;
    logic [2:0]  lvl_snap;

    audio_i2s_dac_tx #(.DATA_WIDTH(16), .FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .sample_data   (sample_data),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .BCLK          (BCLK),
        .DACLRC        (DACLRC),
        .DACDAT        (DACDAT),
        .underflow     (underflow),
        .underflow_clr (underflow_clr),
        .fifo_level    (fifo_level)
    );

    // 32 clk per BCLK period gives BCLK ~3.072 MHz and a 64-bit 48 kHz frame.
    initial clk = 1'b0;
    always #5.086 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt = chk_cnt + 1;
        if (obs === exp) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Expected 32-bit channel slot: one delay bit, the word MSB-first, then padding.
    function automatic logic [31:0] slot_word(input logic [15:0] w);
        return {1'b0, w, 15'b0};
    endfunction

    task automatic push(input logic [31:0] d);
        @(negedge clk);
        sample_data  = d;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        underflow_clr = 1'b1;
        @(negedge clk);
        underflow_clr = 1'b0;
    endtask

    // One BCLK period; mode 1 pushes pp_word and mode 2 pulses underflow_clr
    // in exactly the clk cycle where the synchronized DACLRC edge acts.
    task automatic slot(input logic lrc, input int mode, output logic b);
        repeat (16) @(negedge clk);
        BCLK   = 1'b0;
        DACLRC = lrc;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 2 && mode == 1) begin
                sample_data  = pp_word;
                sample_valid = 1'b1;
            end else if (i == 2 && mode == 2) begin
                underflow_clr = 1'b1;
            end else if (i == 3 && mode != 0) begin
                sample_valid  = 1'b0;
                underflow_clr = 1'b0;
                lvl_snap      = fifo_level;
            end
        end
        b    = DACDAT;
        BCLK = 1'b1;
    endtask

    task automatic frame(input int mode, output logic [31:0] lcap, output logic [31:0] rcap);
        logic b;
        lcap = 32'h0;
        rcap = 32'h0;
        for (int k = 0; k < 64; k++) begin
            slot((k >= 32) ? 1'b1 : 1'b0, (k == 0) ? mode : 0, b);
            if (k < 32) lcap = {lcap[30:0], b};
            else        rcap = {rcap[30:0], b};
        end
    endtask

    initial begin
        logic [31:0] lc, rc;
        logic [31:0] words [5];
        logic        b;
        chk_cnt       = 0;
        pass_cnt      = 0;
        pp_word       = 32'h0;
        lvl_snap      = 3'd0;
        reset         = 1'b1;
        enable        = 1'b1;
        sample_data   = 32'h0;
        sample_valid  = 1'b0;
        underflow_clr = 1'b0;
        BCLK          = 1'b1;
        DACLRC        = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_dacdat", 32'(DACDAT), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ready", 32'(sample_ready), 32'd1);
        check("rst_underflow", 32'(underflow), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Basic stream of one stereo word.
        push(32'hA5F0_0F5A);
        check("basic_level1", 32'(fifo_level), 32'd1);
        frame(0, lc, rc);
        check("basic_left", lc, 32'h52F8_0000);
        check("basic_right", rc, 32'h07AD_0000);
        check("basic_level0", 32'(fifo_level), 32'd0);
        check("basic_no_uf", 32'(underflow), 32'd0);

        // Underflow: empty FIFO at left-frame start, clear, then clear colliding with set.
        frame(0, lc, rc);
        check("uf_left_zero", lc, 32'h0);
        check("uf_right_zero", rc, 32'h0);
        check("uf_set", 32'(underflow), 32'd1);
        clr_pulse();
        check("uf_cleared", 32'(underflow), 32'd0);
        frame(2, lc, rc);
        check("uf_set_wins", 32'(underflow), 32'd1);
        clr_pulse();
        check("uf_cleared2", 32'(underflow), 32'd0);

        // Fill past capacity with the codec idle.
        words[0] = 32'h1111_2222;
        words[1] = 32'h3333_4444;
        words[2] = 32'h5555_6666;
        words[3] = 32'h7777_8888;
        words[4] = 32'h9999_AAAA;
        for (int i = 0; i < 4; i++) begin
            push(words[i]);
            check("full_level", 32'(fifo_level), 32'(i + 1));
        end
        check("full_ready", 32'(sample_ready), 32'd0);
        push(words[4]);
        check("full_level_hold", 32'(fifo_level), 32'd4);
        for (int i = 0; i < 4; i++) begin
            frame(0, lc, rc);
            check("drain_left", lc, slot_word(words[i][31:16]));
            check("drain_right", rc, slot_word(words[i][15:0]));
            check("drain_level", 32'(fifo_level), 32'(3 - i));
            check("drain_ready", 32'(sample_ready), 32'd1);
        end
        frame(0, lc, rc);
        check("fifth_dropped", 32'(underflow), 32'd1);
        check("fifth_left_zero", lc, 32'h0);
        clr_pulse();

        // Push coinciding with a pop at level 2.
        push(32'hDEAD_BEEF);
        push(32'h0123_4567);
        pp_word = 32'hCAFE_F00D;
        frame(1, lc, rc);
        check("pp_level", 32'(lvl_snap), 32'd2);
        check("pp_oldest_left", lc, slot_word(16'hDEAD));
        check("pp_oldest_right", rc, slot_word(16'hBEEF));
        frame(0, lc, rc);
        check("pp_second", lc, slot_word(16'h0123));
        frame(0, lc, rc);
        check("pp_third_left", lc, slot_word(16'hCAFE));
        check("pp_third_right", rc, slot_word(16'hF00D));
        check("pp_level0", 32'(fifo_level), 32'd0);

        // Reset in the middle of a left word, released while DACLRC is high.
        push(32'hFFFF_0000);
        push(32'h1234_5678);
        rc = 32'h0;
        for (int k = 0; k < 64; k++) begin
            slot((k >= 32) ? 1'b1 : 1'b0, 0, b);
            if (k >= 32) rc = {rc[30:0], b};
            if (k == 9) begin
                check("rst_mid_bit", 32'(b), 32'd1);
                check("rst_mid_level", 32'(fifo_level), 32'd1);
                reset = 1'b1;
                #1;
                check("rst_mid_dacdat", 32'(DACDAT), 32'd0);
                check("rst_mid_level0", 32'(fifo_level), 32'd0);
            end
            if (k == 40) reset = 1'b0;
        end
        check("rst_quiet_right", rc, 32'h0);
        check("rst_ready", 32'(sample_ready), 32'd1);
        push(32'h8001_C003);
        frame(0, lc, rc);
        check("rst_resume_left", lc, slot_word(16'h8001));
        check("rst_resume_right", rc, slot_word(16'hC003));

        // Enable dropped mid-word, restored during the right half.
        push(32'hFFFF_1234);
        push(32'h0F0F_F0F0);
        rc = 32'h0;
        for (int k = 0; k < 64; k++) begin
            slot((k >= 32) ? 1'b1 : 1'b0, 0, b);
            if (k >= 32) rc = {rc[30:0], b};
            if (k == 5) begin
                check("en_mid_bit", 32'(b), 32'd1);
                enable = 1'b0;
                @(negedge clk);
                check("en_off_dacdat", 32'(DACDAT), 32'd0);
                check("en_off_level", 32'(fifo_level), 32'd1);
            end
            if (k == 40) enable = 1'b1;
        end
        check("en_quiet_right", rc, 32'h0);
        check("en_level_kept", 32'(fifo_level), 32'd1);
        check("en_no_uf", 32'(underflow), 32'd0);
        frame(0, lc, rc);
        check("en_resume_left", lc, slot_word(16'h0F0F));
        check("en_resume_right", rc, slot_word(16'hF0F0));
        check("en_level0", 32'(fifo_level), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
